// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: buffers producer writes and launches one frame at a time
// over the DV/Done handshake. Only one byte is ever outstanding at the serialiser.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              MAX10_CLK1_50,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, GAP} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);

  // full is taken from the registered count, so a pop in LOAD never frees a slot for the same cycle
  assign wr_ok = wr_en & ~full;
  assign rd_ok = (state == LOAD);

  always_ff @(posedge MAX10_CLK1_50) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // IDLE also waits on i_Tx_Active so a frame left running across our reset finishes first
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      o_Tx_DV <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty && !i_Tx_Active) state <= LOAD;
        end
        LOAD: begin
          o_Tx_Byte <= mem[rd_ptr];
          o_Tx_DV   <= 1'b1;
          state     <= START;
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (i_Tx_Done) state <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; the uart_tx side is driven by hand from the same sequence.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       dv;
  logic [7:0] tx_byte;
  logic       act;
  logic       done;

  int total_cnt = 0;
  int pass_cnt  = 0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .busy          (busy),
    .o_Tx_DV       (dv),
    .o_Tx_Byte     (tx_byte),
    .i_Tx_Active   (act),
    .i_Tx_Done     (done)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dv(input string tag);
    int n = 0;
    while (dv !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(dv), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dv_seen;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; act = 1'b0; done = 1'b0;
    repeat (2) tick();
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_dv",       32'(dv),       32'd0);
    chk("rst_byte",     32'(tx_byte),  32'h00);
    chk("rst_busy",     32'(busy),     32'd0);
    rst = 1'b0;
    tick();

    // single byte: write in cycle 0, LOAD in 2, DV in 3
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("t1_empty_c1", 32'(empty), 32'd0);
    chk("t1_count_c1", 32'(count), 32'd1);
    chk("t1_dv_c1",    32'(dv),    32'd0);
    tick();
    chk("t1_busy_c2",  32'(busy),  32'd1);
    chk("t1_dv_c2",    32'(dv),    32'd0);
    tick();
    chk("t1_dv_c3",    32'(dv),      32'd1);
    chk("t1_byte_c3",  32'(tx_byte), 32'hA5);
    chk("t1_count_c3", 32'(count),   32'd0);
    tick();
    chk("t1_dv_c4",    32'(dv),      32'd0);
    chk("t1_byte_c4",  32'(tx_byte), 32'hA5);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t1_gap_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_idle_busy", 32'(busy),  32'd0);
    chk("t1_idle_empty", 32'(empty), 32'd1);

    // fill to DEPTH with the line held active, then overflow
    act = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("t2_full",  32'(full),  32'd1);
    chk("t2_count", 32'(count), 32'd16);
    chk("t2_busy",  32'(busy),  32'd0);
    wr_en = 1'b1; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    chk("t2_ovf_pulse", 32'(overflow), 32'd1);
    chk("t2_ovf_count", 32'(count),    32'd16);
    tick();
    chk("t2_ovf_clear", 32'(overflow), 32'd0);

    // write while full in the LOAD cycle: rejected, count 16 -> 15
    act = 1'b0;
    tick();
    chk("t4_load_busy",  32'(busy),  32'd1);
    chk("t4_load_count", 32'(count), 32'd16);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("t4_ovf",   32'(overflow), 32'd1);
    chk("t4_count", 32'(count),    32'd15);
    chk("t4_full",  32'(full),     32'd0);
    chk("t4_dv",    32'(dv),       32'd1);
    chk("t4_byte",  32'(tx_byte),  32'h00);

    // no Done: hold in WAIT_DONE, then DV 4 cycles after Done
    dv_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      dv_seen = dv_seen | dv;
    end
    chk("t6_no_dv",   32'(dv_seen), 32'd0);
    chk("t6_busy",    32'(busy),    32'd1);
    chk("t6_count",   32'(count),   32'd15);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t6_dv_d1", 32'(dv), 32'd0);
    tick();
    chk("t6_dv_d2", 32'(dv), 32'd0);
    tick();
    chk("t6_dv_d3", 32'(dv), 32'd0);
    tick();
    chk("t6_dv_d4",   32'(dv),      32'd1);
    chk("t6_byte_d4", 32'(tx_byte), 32'h01);

    // stream 00..0F with a behavioural serialiser
    rst = 1'b1;
    tick();
    rst = 1'b0;
    act = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_dv($sformatf("t3_dv_%0d", i));
      chk($sformatf("t3_byte_%0d", i), 32'(tx_byte), 32'(i));
      act = 1'b1;
      repeat (3) tick();
      act = 1'b0; done = 1'b1;
      tick();
      done = 1'b0;
    end
    repeat (3) tick();
    chk("t3_end_empty", 32'(empty), 32'd1);
    chk("t3_end_busy",  32'(busy),  32'd0);

    // reset while WAIT_DONE with 5 queued and the line active
    act = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    act = 1'b1;
    chk("t5_pre_count", 32'(count), 32'd5);
    chk("t5_pre_busy",  32'(busy),  32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_busy",  32'(busy),  32'd0);
    chk("t5_rst_empty", 32'(empty), 32'd1);
    tick();
    rst = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    chk("t5_new_count", 32'(count), 32'd1);
    dv_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      dv_seen = dv_seen | dv;
    end
    chk("t5_blocked_dv",   32'(dv_seen), 32'd0);
    chk("t5_blocked_busy", 32'(busy),    32'd0);
    act = 1'b0;
    tick();
    chk("t5_load_busy", 32'(busy), 32'd1);
    tick();
    chk("t5_dv",   32'(dv),      32'd1);
    chk("t5_byte", 32'(tx_byte), 32'h77);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
